mean_filter_frame_ctrl: RTL and testbench



---
 rtl/mean_filter_frame_ctrl.sv | 203 ++++++++++++++++++++
 tb/tb_mean_filter_frame_ctrl.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mean_filter_frame_ctrl.sv
// Frame sequencer ahead of the mean filter: locks to SOF, regenerates markers, appends flush beats.
// Define MF_CTRL_STATS_EN to build the saturating frame_cnt / err_cnt counters.
module mean_filter_frame_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAME_WIDTH = 640,
    parameter int FRAME_HEIGHT = 512,
    parameter int WINDOW_SIZE = 3,
    parameter logic [DATA_WIDTH-1:0] FLUSH_DATA = '0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    input  logic                  s_axis_tuser,
    output logic                  s_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    output logic                  m_axis_tlast,
    output logic                  m_axis_tuser,
    input  logic                  m_axis_tready,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  sync_err,
    output logic [15:0]           frame_cnt,
    output logic [15:0]           err_cnt
);

    localparam int FLUSH_LEN = (WINDOW_SIZE - 1) * FRAME_WIDTH + (WINDOW_SIZE - 1)
                             + 2 * $clog2(WINDOW_SIZE);
    localparam int HW = $clog2(FRAME_WIDTH + 1);
    localparam int VW = $clog2(FRAME_HEIGHT + 1);
    localparam int FW = $clog2(FLUSH_LEN + 1);
    localparam logic [HW-1:0] H_LAST = HW'(FRAME_WIDTH - 1);
    localparam logic [VW-1:0] V_LAST = VW'(FRAME_HEIGHT - 1);
    localparam logic [FW-1:0] F_LAST = FW'(FLUSH_LEN - 1);
    localparam logic ONE_COL = (FRAME_WIDTH == 1);

    typedef enum logic [1:0] {SYNC, PASS, FLUSH} state_t;

    state_t          state_q, state_d;
    logic [HW-1:0]   hcnt_q, hcnt_d;
    logic [VW-1:0]   vcnt_q, vcnt_d;
    logic [FW-1:0]   fcnt_q, fcnt_d;
    logic            frame_done_q, frame_done_d;
    logic            sync_err_q, sync_err_d;

    logic            s_fire, m_fire;
    logic            at_sof, at_eol;
    logic            early_sof, tlast_bad, adv;
    logic [HW-1:0]   h_base;
    logic [VW-1:0]   v_base;
    logic            base_eol, base_eof;

    assign at_sof = (hcnt_q == '0) && (vcnt_q == '0);
    assign at_eol = (hcnt_q == H_LAST);

    always_comb begin
        m_axis_tdata  = s_axis_tdata;
        m_axis_tvalid = 1'b0;
        m_axis_tuser  = 1'b0;
        m_axis_tlast  = 1'b0;
        s_axis_tready = 1'b1;
        unique case (state_q)
            SYNC: begin
                if (s_axis_tuser) begin
                    m_axis_tvalid = s_axis_tvalid;
                    s_axis_tready = m_axis_tready;
                    m_axis_tuser  = 1'b1;
                    m_axis_tlast  = ONE_COL;
                end
            end
            PASS: begin
                m_axis_tvalid = s_axis_tvalid;
                s_axis_tready = m_axis_tready;
                m_axis_tuser  = at_sof | s_axis_tuser;
                m_axis_tlast  = at_eol;
            end
            FLUSH: begin
                m_axis_tdata  = FLUSH_DATA;
                m_axis_tvalid = 1'b1;
                s_axis_tready = 1'b0;
            end
            default: ;
        endcase
    end

    assign s_fire = s_axis_tvalid & s_axis_tready;
    assign m_fire = m_axis_tvalid & m_axis_tready;

    // A SOF beat (initial or early) is treated as the pixel at (0,0).
    assign early_sof = (state_q == PASS) && s_axis_tuser && !at_sof;
    assign tlast_bad = (state_q == PASS) && (s_axis_tlast != at_eol);
    assign h_base    = (state_q == PASS && !early_sof) ? hcnt_q : '0;
    assign v_base    = (state_q == PASS && !early_sof) ? vcnt_q : '0;
    assign base_eol  = (h_base == H_LAST);
    assign base_eof  = base_eol && (v_base == V_LAST);

    always_comb begin
        state_d      = state_q;
        hcnt_d       = hcnt_q;
        vcnt_d       = vcnt_q;
        fcnt_d       = fcnt_q;
        frame_done_d = 1'b0;
        sync_err_d   = 1'b0;
        adv          = 1'b0;
        unique case (state_q)
            SYNC: begin
                if (s_fire && s_axis_tuser) adv = 1'b1;
            end
            PASS: begin
                if (s_fire) begin
                    if (early_sof) begin
                        sync_err_d = 1'b1;
                        adv        = 1'b1;
                    end else if (tlast_bad) begin
                        sync_err_d = 1'b1;
                        state_d    = SYNC;
                        hcnt_d     = '0;
                        vcnt_d     = '0;
                    end else begin
                        adv = 1'b1;
                    end
                end
            end
            FLUSH: begin
                if (m_fire) begin
                    if (fcnt_q == F_LAST) begin
                        state_d      = SYNC;
                        fcnt_d       = '0;
                        frame_done_d = 1'b1;
                    end else begin
                        fcnt_d = fcnt_q + FW'(1);
                    end
                end
            end
            default: state_d = SYNC;
        endcase
        if (adv) begin
            if (base_eof) begin
                state_d = FLUSH;
                hcnt_d  = '0;
                vcnt_d  = '0;
                fcnt_d  = '0;
            end else begin
                state_d = PASS;
                hcnt_d  = base_eol ? '0 : h_base + HW'(1);
                vcnt_d  = base_eol ? v_base + VW'(1) : v_base;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= SYNC;
            hcnt_q       <= '0;
            vcnt_q       <= '0;
            fcnt_q       <= '0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            hcnt_q       <= hcnt_d;
            vcnt_q       <= vcnt_d;
            fcnt_q       <= fcnt_d;
            frame_done_q <= frame_done_d;
            sync_err_q   <= sync_err_d;
        end
    end

    assign busy       = (state_q != SYNC);
    assign frame_done = frame_done_q;
    assign sync_err   = sync_err_q;

`ifdef MF_CTRL_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (frame_done_d && frame_cnt_q != 16'hFFFF) frame_cnt_d = frame_cnt_q + 16'd1;
        if (sync_err_d && err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif

endmodule

// File: tb/tb_mean_filter_frame_ctrl.sv
// Bench for mean_filter_frame_ctrl: 4x3 frame, 3x3 window, 14 flush beats.
// Directed sequences plus randomized frames checked against a pixel-index model.
module tb_mean_filter_frame_ctrl;

    localparam int W  = 4;
    localparam int H  = 3;
    localparam int FL = 14;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  s_axis_tdata = '0;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tlast = 1'b0;
    logic        s_axis_tuser = 1'b0;
    logic        s_axis_tready;
    logic [7:0]  m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tlast;
    logic        m_axis_tuser;
    logic        m_axis_tready = 1'b0;
    logic        busy;
    logic        frame_done;
    logic        sync_err;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    mean_filter_frame_ctrl #(
        .DATA_WIDTH(8), .FRAME_WIDTH(W), .FRAME_HEIGHT(H),
        .WINDOW_SIZE(3), .FLUSH_DATA(8'h00)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
        .s_axis_tready(s_axis_tready),
        .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tready(m_axis_tready),
        .busy(busy), .frame_done(frame_done), .sync_err(sync_err),
        .frame_cnt(frame_cnt), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: mode 0=sync 1=pass 2=flush; pix = linear pixel index
    int mode = 0, pix = 0, fl = 0;
    int done_p = 0, err_p = 0, fcnt_m = 0, ecnt_m = 0;
    int cyc = 0;
    int dut_fires = 0, dut_dones = 0, dut_errs = 0;
    logic e_rdy_last;
    logic smp_rdy, smp_vld, smp_busy, smp_done, smp_err, smp_usr;

    task automatic chk(input string n, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", n, act, exp, $time);
        end
    endtask

    task automatic step(input logic [7:0] d, input logic v, input logic l,
                        input logic u, input logic mr, input logic r);
        logic e_rdy, e_vld, e_usr, e_lst;
        logic [7:0] e_dat;
        int dn, er;
        @(negedge clk);
        s_axis_tdata = d; s_axis_tvalid = v; s_axis_tlast = l;
        s_axis_tuser = u; m_axis_tready = mr; rst_n = r;
        #1;
        e_dat = d; e_usr = 1'b0; e_lst = 1'b0;
        if (mode == 0) begin
            e_vld = u ? v : 1'b0;
            e_rdy = u ? mr : 1'b1;
            e_usr = u;
        end else if (mode == 1) begin
            e_vld = v;
            e_rdy = mr;
            e_usr = (pix == 0) || u;
            e_lst = (pix % W) == W - 1;
        end else begin
            e_vld = 1'b1; e_rdy = 1'b0; e_dat = 8'h00;
        end
        e_rdy_last = e_rdy;
        chk("s_tready", s_axis_tready, e_rdy);
        chk("m_tvalid", m_axis_tvalid, e_vld);
        chk("m_tdata", m_axis_tdata, e_dat);
        if (e_vld) begin
            chk("m_tuser", m_axis_tuser, e_usr);
            chk("m_tlast", m_axis_tlast, e_lst);
        end
        chk("busy", busy, mode != 0);
        chk("frame_done", frame_done, done_p);
        chk("sync_err", sync_err, err_p);
`ifdef MF_CTRL_STATS_EN
        chk("frame_cnt", frame_cnt, fcnt_m);
        chk("err_cnt", err_cnt, ecnt_m);
`else
        chk("frame_cnt", frame_cnt, 0);
        chk("err_cnt", err_cnt, 0);
`endif
        smp_rdy = s_axis_tready; smp_vld = m_axis_tvalid; smp_busy = busy;
        smp_done = frame_done; smp_err = sync_err; smp_usr = m_axis_tuser;
        if (m_axis_tvalid && m_axis_tready) dut_fires++;
        if (frame_done) dut_dones++;
        if (sync_err) dut_errs++;
        cyc++;
        @(posedge clk);
        dn = 0; er = 0;
        if (!r) begin
            mode = 0; pix = 0; fl = 0; fcnt_m = 0; ecnt_m = 0;
        end else if (mode == 0) begin
            if (u && v && mr) begin mode = 1; pix = 1; end
        end else if (mode == 1) begin
            if (v && mr) begin
                if (u && pix != 0) begin
                    er = 1; pix = 1;
                end else if (l != ((pix % W) == W - 1)) begin
                    er = 1; mode = 0; pix = 0;
                end else begin
                    pix++;
                    if (pix == W * H) begin mode = 2; pix = 0; fl = 0; end
                end
            end
        end else begin
            if (mr) begin
                fl++;
                if (fl == FL) begin mode = 0; fl = 0; dn = 1; end
            end
        end
        done_p = dn; err_p = er;
        if (dn && fcnt_m < 65535) fcnt_m++;
        if (er && ecnt_m < 65535) ecnt_m++;
    endtask

    // Emits nb beats; sof2/bad are beat indices of an early SOF / wrong tlast (-1: none)
    task automatic send(input int nb, input int sof2, input int bad, input bit garbage,
                        input int pv, input int pr, input bit tog, input logic [7:0] base);
        int b = 0, guard = 0, p;
        logic v, u, l, mr;
        while (b < nb && guard < 2000) begin
            p  = (sof2 >= 0 && b >= sof2) ? b - sof2 : b;
            u  = !garbage && (b == 0 || b == sof2);
            l  = (((p % W) == W - 1) ^ (b == bad)) && !garbage;
            v  = $urandom_range(99) < pv;
            mr = tog ? logic'(cyc % 2) : logic'($urandom_range(99) < pr);
            step(base + 8'(b), v, l, u, mr, 1'b1);
            if (v && e_rdy_last) b++;
            guard++;
        end
        chk("send_guard", guard < 2000, 1);
    endtask

    task automatic drain(input int pr, input bit tog);
        int g = 0;
        logic mr;
        while (mode != 0 && g < 500) begin
            mr = tog ? logic'(cyc % 2) : logic'($urandom_range(99) < pr);
            step(8'h00, 1'b0, 1'b0, 1'b0, mr, 1'b1);
            g++;
        end
        chk("drain_guard", g < 500, 1);
    endtask

    typedef struct {
        logic v; logic u; logic mr; logic [7:0] d;
        logic e_rdy; logic e_vld;
    } vec_t;

    vec_t tbl [6];

    initial begin
        #5ms;
        $display("FAIL global_timeout t=%0t", $time);
        $fatal(1, "timeout");
    end

    initial begin
        int d0, f0, e0;
        tbl[0] = '{1'b1, 1'b0, 1'b1, 8'h11, 1'b1, 1'b0};
        tbl[1] = '{1'b1, 1'b0, 1'b0, 8'h22, 1'b1, 1'b0};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 8'h33, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b1};
        tbl[4] = '{1'b0, 1'b0, 1'b0, 8'h55, 1'b1, 1'b0};
        tbl[5] = '{1'b0, 1'b1, 1'b0, 8'h66, 1'b0, 1'b0};

        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

        // SYNC-state combinational behaviour; no row completes a SOF handshake
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            s_axis_tvalid = tbl[i].v; s_axis_tuser = tbl[i].u;
            s_axis_tlast = 1'b0; m_axis_tready = tbl[i].mr;
            s_axis_tdata = tbl[i].d;
            #1;
            chk("tbl_s_tready", s_axis_tready, tbl[i].e_rdy);
            chk("tbl_m_tvalid", m_axis_tvalid, tbl[i].e_vld);
            chk("tbl_m_tdata", m_axis_tdata, tbl[i].d);
            chk("tbl_busy", busy, 0);
        end

        // Clean frame, data 1..12, always ready
        send(12, -1, -1, 1'b0, 100, 100, 1'b0, 8'd1);
        for (int i = 0; i < FL; i++) begin
            step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
            chk("flush_s_tready", smp_rdy, 0);
        end
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("clean_done_pulse", smp_done, 1);
        chk("clean_idle", smp_busy, 0);
        chk("clean_dones", dut_dones, 1);

        // Pre-SOF garbage then a clean frame
        send(5, -1, -1, 1'b1, 100, 100, 1'b0, 8'h40);
        chk("garbage_busy", busy, 0);
        send(12, -1, -1, 1'b0, 100, 100, 1'b0, 8'd1);
        drain(100, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("garbage_dones", dut_dones, 2);

        // Backpressure toggling every cycle
        f0 = dut_fires;
        send(12, -1, -1, 1'b0, 100, 0, 1'b1, 8'h80);
        drain(0, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("bp_fires", dut_fires - f0, 26);
        chk("bp_dones", dut_dones, 3);

        // Short line: tlast on beat 3
        e0 = dut_errs; d0 = dut_dones;
        send(3, -1, 2, 1'b0, 100, 100, 1'b0, 8'h10);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("short_err_pulse", smp_err, 1);
        chk("short_no_flush", smp_busy, 0);
        send(12, -1, -1, 1'b0, 100, 100, 1'b0, 8'h20);
        drain(100, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("short_errs", dut_errs - e0, 1);
        chk("short_dones", dut_dones - d0, 1);

        // Early SOF on beat 7: frame restarts there
        e0 = dut_errs; d0 = dut_dones;
        send(6, -1, -1, 1'b0, 100, 100, 1'b0, 8'h30);
        step(8'h36, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1);
        chk("esof_m_tuser", smp_usr, 1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("esof_err_pulse", smp_err, 1);
        for (int b = 1; b < 11; b++)
            step(8'h36 + 8'(b), 1'b1, logic'((b % W) == W - 1), 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("esof_not_yet", smp_rdy, 1);
        step(8'h41, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("esof_flush", smp_rdy, 0);
        drain(100, 1'b0);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("esof_errs", dut_errs - e0, 1);
        chk("esof_dones", dut_dones - d0, 1);

        // Reset on flush beat 5
        d0 = dut_dones;
        send(12, -1, -1, 1'b0, 100, 100, 1'b0, 8'h50);
        for (int i = 0; i < 4; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("rst_during_flush_vld", smp_vld, 1);
        step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_busy", smp_busy, 0);
        chk("rst_m_tvalid", smp_vld, 0);
        chk("rst_s_tready", smp_rdy, 1);
        chk("rst_no_done", smp_done, 0);
        for (int i = 0; i < 20; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("rst_dones", dut_dones - d0, 0);

        // Randomized frames with random errors and flow control
        for (int k = 0; k < 30; k++) begin
            int kind, pv, pr;
            kind = $urandom_range(3);
            pv = $urandom_range(50, 100);
            pr = $urandom_range(50, 100);
            if (kind == 1) send($urandom_range(1, 4), -1, -1, 1'b1, pv, pr, 1'b0, 8'hA0);
            if (kind == 2) begin
                int bad;
                bad = $urandom_range(0, 10);
                send(bad + 1, -1, bad, 1'b0, pv, pr, 1'b0, 8'($urandom));
            end else if (kind == 3) begin
                int s2;
                s2 = $urandom_range(1, 11);
                send(s2 + W * H, s2, -1, 1'b0, pv, pr, 1'b0, 8'($urandom));
            end else begin
                send(W * H, -1, -1, 1'b0, pv, pr, 1'b0, 8'($urandom));
            end
            drain(pr, 1'b0);
        end
        for (int i = 0; i < 3; i++) step(8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
